bus_arbiter_rr: RTL and testbench
=================================

// Module: bus_arbiter_rr
// PURPOSE
//  Round-robin arbiter sharing the single bus master port between NUM_MASTERS requesters (ramDmaCi DMA
//  engines, CPU instruction/data fetch, camera/display DMAs). Samples request lines, issues a one-cycle
//  granted pulse to the winner, then owns the bus until the winner's transaction ends (end/error).
//  Sits between the masters' request/granted pins and the shared bus begin/end/error signals.
// PARAMETERS
//  NUM_MASTERS    4    number of requesters, 2..16
//  BEGIN_WAIT     4    cycles after grant within which begin_transaction_in must appear, 1..15
//  TIMEOUT_CYCLES 1024 max ACTIVE cycles before forced release (only with BUS_ARB_TIMEOUT_EN)
// PORTS
//  clock                 in   1            system clock, all logic on rising edge
//  reset                 in   1            synchronous, active-low
//  request               in   NUM_MASTERS  per-master request level, held until granted
//  granted               out  NUM_MASTERS  one-hot, one-cycle grant pulse
//  begin_transaction_in  in   1            bus: owner starts transaction
//  end_transaction_in    in   1            bus: transaction complete
//  error_in              in   1            bus: transaction aborted by slave
//  bus_owner             out  IDX_W        index of current/last owner (IDX_W = clog2(NUM_MASTERS))
//  bus_busy              out  1            high from grant cycle until release
//  timeout_error         out  1            one-cycle pulse on forced release (0 when macro off)
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE, granted=0, bus_owner=0, bus_busy=0, timeout_error=0, ptr=0.
//  States: IDLE -> GRANT -> WAIT_BEGIN -> ACTIVE -> IDLE.
//  IDLE: if any request, pick first set bit scanning ptr, ptr+1, ... mod NUM_MASTERS; next cycle
//   granted[w]=1 (registered, latency 1 from sampled request), bus_owner=w, bus_busy=1, ptr<=w+1 mod N.
//  GRANT: granted pulse lasts exactly one cycle; -> WAIT_BEGIN, counter cleared.
//  WAIT_BEGIN: begin_transaction_in -> ACTIVE. No begin within BEGIN_WAIT cycles -> IDLE (abandoned grant,
//   ptr already advanced, no error pulse).
//  ACTIVE: end_transaction_in or error_in -> IDLE; both in same cycle = one release. Next grant earliest
//   one cycle after release cycle (IDLE evaluation cycle); bus_busy drops with IDLE entry.
//  Request deasserted after grant: ignored; release still waits for end/error/abandon.
//  end/error/begin outside expected states: ignored. Request of owner re-asserted: rejoins round robin,
//   lowest priority because ptr passed it.
//  Single requester: granted back-to-back with one IDLE cycle between transactions.
//  Reset mid-transaction: immediate return to reset values, granted never left high.
// CONFIGURATION
//  BUS_ARB_TIMEOUT_EN defined: ACTIVE counter; at TIMEOUT_CYCLES cycles without end/error -> IDLE with
//   timeout_error=1 for one cycle (same cycle as bus_busy fall). Counter clears on each ACTIVE entry.
//  Not defined: no counter, ACTIVE waits indefinitely, timeout_error tied 0.
// STRUCTURE
//  Shared package bus_arb_pkg: state encoding (IDLE/GRANT/WAIT_BEGIN/ACTIVE), clog2-based IDX_W helper,
//   default BEGIN_WAIT / TIMEOUT_CYCLES constants.
//  Sub-module rr_priority_picker: combinational request+ptr -> winner index + valid (rotate, find-first,
//   unrotate). FSM, counters and registered outputs in bus_arbiter_rr.
// TESTING
//  1 request=0010 from reset -> granted=0010 one cycle later for 1 cycle, bus_owner=1, bus_busy=1.
//  2 request=1111, each master completes begin+end -> grant order 0,1,2,3,0 (ptr starts 0), never two bits.
//  3 grant to master 2, no begin for 4 cycles -> IDLE, bus_busy=0, next grant goes to master 3 if requesting.
//  4 ACTIVE, error_in=1 for 1 cycle -> IDLE next cycle, new grant one cycle later; end+error same cycle -> one release.
//  5 BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, begin then silence -> timeout_error pulse at 16th ACTIVE cycle;
//    macro off -> still ACTIVE after 100 cycles.
//  6 reset=0 during ACTIVE with request=1111 -> next cycle all outputs 0; after release first grant to master 0.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM encoding, index-width helper
// and default timing constants.
package bus_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE       = 2'd0;
    localparam arb_state_t ST_GRANT      = 2'd1;
    localparam arb_state_t ST_WAIT_BEGIN = 2'd2;
    localparam arb_state_t ST_ACTIVE     = 2'd3;

    localparam int DEF_BEGIN_WAIT     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // A two-master arbiter still needs a one-bit owner index.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: rotate the request vector so ptr sits at bit 0,
// take the first set bit, then map that position back to a master index.
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     request,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [N-1:0] rotated;
    int           first;
    int           sum;

    always_comb begin
        rotated = '0;
        first   = 0;
        sum     = 0;
        valid   = 1'b0;
        for (int i = 0; i < N; i++) begin
            rotated[i] = request[(int'(ptr) + i) % N];
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                first = i;
                valid = 1'b1;
            end
        end
        // ptr < N and first < N, so a single subtraction completes the modulo.
        sum = int'(ptr) + first;
        if (sum >= N) begin
            sum = sum - N;
        end
        winner = IDX_W'(sum);
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin owner of the shared bus master port. Optional forced release of a stalled
// ACTIVE transaction is compiled in with BUS_ARB_TIMEOUT_EN.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int  NUM_MASTERS    = 4,
    parameter int  BEGIN_WAIT     = DEF_BEGIN_WAIT,
    parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDX_W          = idx_width(NUM_MASTERS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] request,
    output logic [NUM_MASTERS-1:0] granted,
    input  logic                   begin_transaction_in,
    input  logic                   end_transaction_in,
    input  logic                   error_in,
    output logic [IDX_W-1:0]       bus_owner,
    output logic                   bus_busy,
    output logic                   timeout_error,
    output arb_state_t             fsm_state
);

    localparam logic [3:0] WAIT_LAST = 4'(BEGIN_WAIT - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [3:0]       wait_cnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [IDX_W-1:0] ptr_after_pick;

    rr_priority_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .request (request),
        .ptr     (ptr),
        .winner  (pick_idx),
        .valid   (pick_valid)
    );

    assign ptr_after_pick = (pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
    assign fsm_state      = state;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int             TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] active_cnt;
    logic            timeout_pulse;

    assign timeout_error = timeout_pulse;
`else
    assign timeout_error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            granted   <= '0;
            bus_owner <= '0;
            bus_busy  <= 1'b0;
            ptr       <= '0;
            wait_cnt  <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            active_cnt    <= '0;
            timeout_pulse <= 1'b0;
`endif
        end else begin
            granted <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            timeout_pulse <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state     <= ST_GRANT;
                        granted   <= NUM_MASTERS'(1) << pick_idx;
                        bus_owner <= pick_idx;
                        bus_busy  <= 1'b1;
                        ptr       <= ptr_after_pick;
                    end
                end
                ST_GRANT: begin
                    state    <= ST_WAIT_BEGIN;
                    wait_cnt <= '0;
                end
                ST_WAIT_BEGIN: begin
                    // An abandoned grant just frees the bus; ptr already moved past the owner.
                    if (begin_transaction_in) begin
                        state <= ST_ACTIVE;
`ifdef BUS_ARB_TIMEOUT_EN
                        active_cnt <= '0;
`endif
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= ST_IDLE;
                        bus_busy <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (end_transaction_in || error_in) begin
                        state    <= ST_IDLE;
                        bus_busy <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
                    end else if (active_cnt == TO_LAST) begin
                        state         <= ST_IDLE;
                        bus_busy      <= 1'b0;
                        timeout_pulse <= 1'b1;
                    end else begin
                        active_cnt <= active_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bus_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios plus randomized transactions
// checked against a round-robin reference model; handles BUS_ARB_TIMEOUT_EN either way.
module tb_bus_arbiter_rr;

    localparam int N          = 4;
    localparam int BEGIN_WAIT = 4;
    localparam int TO_CYC     = 16;

    localparam int M_END     = 0;
    localparam int M_ERROR   = 1;
    localparam int M_BOTH    = 2;
    localparam int M_ABANDON = 3;
    localparam int M_SILENT  = 4;
    localparam int M_RESET   = 5;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] request;
    logic [N-1:0] granted;
    logic         begin_transaction_in;
    logic         end_transaction_in;
    logic         error_in;
    logic [1:0]   bus_owner;
    logic         bus_busy;
    logic         timeout_error;
    logic [1:0]   fsm_state;

    int vectors     = 0;
    int miscompares = 0;
    int rr_ptr      = 0;
    int last_w      = -1;
    int order_exp[5] = '{0, 1, 2, 3, 0};

    bus_arbiter_rr #(
        .NUM_MASTERS    (N),
        .BEGIN_WAIT     (BEGIN_WAIT),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .request              (request),
        .granted              (granted),
        .begin_transaction_in (begin_transaction_in),
        .end_transaction_in   (end_transaction_in),
        .error_in             (error_in),
        .bus_owner            (bus_owner),
        .bus_busy             (bus_busy),
        .timeout_error        (timeout_error),
        .fsm_state            (fsm_state)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: first requesting master at or after rr_ptr, wrapping around.
    function automatic int model_pick(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            if (m[(rr_ptr + i) % N]) return (rr_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset                = 1'b0;
        request              = '0;
        begin_transaction_in = 1'b0;
        end_transaction_in   = 1'b0;
        error_in             = 1'b0;
        step();
        step();
        check("rst_granted", 32'(granted), 32'd0);
        check("rst_owner", 32'(bus_owner), 32'd0);
        check("rst_busy", 32'(bus_busy), 32'd0);
        check("rst_timeout", 32'(timeout_error), 32'd0);
        reset  = 1'b1;
        rr_ptr = 0;
    endtask

    task automatic txn(input logic [N-1:0] mask, input int mode);
        int w;
        int d;
        int len;
        request = mask;
        w = model_pick(mask);
        step();
        check("grant", 32'(granted), 32'(1) << w);
        check("owner", 32'(bus_owner), 32'(w));
        check("busy_at_grant", 32'(bus_busy), 32'd1);
        last_w  = w;
        rr_ptr  = (w + 1) % N;
        request = mask & ~(N'(1) << w);
        step();
        check("pulse_len", 32'(granted), 32'd0);
        check("busy_wait", 32'(bus_busy), 32'd1);

        if (mode == M_ABANDON) begin
            for (int i = 1; i <= BEGIN_WAIT; i++) begin
                end_transaction_in = 1'($urandom_range(0, 1));
                error_in           = 1'($urandom_range(0, 1));
                step();
                check("abandon_busy", 32'(bus_busy), (i < BEGIN_WAIT) ? 32'd1 : 32'd0);
                check("abandon_grant", 32'(granted), 32'd0);
            end
            end_transaction_in = 1'b0;
            error_in           = 1'b0;
            check("abandon_no_timeout", 32'(timeout_error), 32'd0);
            return;
        end

        d = $urandom_range(0, BEGIN_WAIT - 1);
        for (int i = 0; i < d; i++) begin
            end_transaction_in = 1'($urandom_range(0, 1));
            error_in           = 1'($urandom_range(0, 1));
            step();
            check("stray_end_ignored", 32'(bus_busy), 32'd1);
        end
        end_transaction_in   = 1'b0;
        error_in             = 1'b0;
        begin_transaction_in = 1'b1;
        step();
        begin_transaction_in = 1'b0;
        check("busy_begin", 32'(bus_busy), 32'd1);

        if (mode == M_SILENT) begin
`ifdef BUS_ARB_TIMEOUT_EN
            for (int i = 1; i <= TO_CYC; i++) begin
                step();
                check("to_busy", 32'(bus_busy), (i < TO_CYC) ? 32'd1 : 32'd0);
                check("to_pulse", 32'(timeout_error), (i == TO_CYC) ? 32'd1 : 32'd0);
            end
            step();
            check("to_pulse_len", 32'(timeout_error), 32'd0);
`else
            repeat (100) step();
            check("active_holds", 32'(bus_busy), 32'd1);
            check("no_timeout", 32'(timeout_error), 32'd0);
            end_transaction_in = 1'b1;
            step();
            end_transaction_in = 1'b0;
            check("late_release", 32'(bus_busy), 32'd0);
`endif
            return;
        end

        if (mode == M_RESET) begin
            step();
            step();
            reset   = 1'b0;
            request = '1;
            step();
            check("midrst_granted", 32'(granted), 32'd0);
            check("midrst_owner", 32'(bus_owner), 32'd0);
            check("midrst_busy", 32'(bus_busy), 32'd0);
            check("midrst_timeout", 32'(timeout_error), 32'd0);
            reset  = 1'b1;
            rr_ptr = 0;
            return;
        end

        len = $urandom_range(0, 6);
        for (int i = 0; i < len; i++) begin
            begin_transaction_in = 1'($urandom_range(0, 1));
            step();
            check("active_busy", 32'(bus_busy), 32'd1);
            check("active_grant", 32'(granted), 32'd0);
        end
        begin_transaction_in = 1'b0;
        end_transaction_in   = (mode == M_END || mode == M_BOTH);
        error_in             = (mode == M_ERROR || mode == M_BOTH);
        step();
        end_transaction_in = 1'b0;
        error_in           = 1'b0;
        check("release_busy", 32'(bus_busy), 32'd0);
        check("release_grant", 32'(granted), 32'd0);
        check("release_timeout", 32'(timeout_error), 32'd0);
    endtask

    initial begin
        do_reset();

        // Single request from reset.
        txn(4'b0010, M_END);
        check("first_owner", 32'(last_w), 32'd1);

        // All four requesting: strict rotation starting at master 0.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            txn(4'b1111, M_END);
            check("rr_order", 32'(last_w), 32'(order_exp[k]));
        end

        // Abandoned grant to master 2, then master 3 is next.
        txn(4'b0100, M_ABANDON);
        check("abandon_owner", 32'(last_w), 32'd2);
        txn(4'b1100, M_END);
        check("after_abandon", 32'(last_w), 32'd3);

        // Error release, simultaneous end+error, single requester back to back.
        txn(4'b0001, M_ERROR);
        txn(4'b0001, M_BOTH);
        txn(4'b0001, M_END);
        check("single_req", 32'(last_w), 32'd0);

        // Silent ACTIVE: forced release or indefinite hold depending on build.
        txn(4'b1000, M_SILENT);

        // Reset during ACTIVE, then first grant returns to master 0.
        txn(4'b0110, M_RESET);
        txn(4'b1111, M_END);
        check("post_reset_owner", 32'(last_w), 32'd0);

        for (int k = 0; k < 40; k++) begin
            txn(N'($urandom_range(1, 15)), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
